// File: rtl/signal_phase_scheduler_if.sv
// Sensor and lamp bundle for the actuated two-road signal scheduler.
// The slave side is the scheduler; the master side is whatever drives the
// vehicle sensors and watches the lamps.
interface signal_phase_scheduler_if;
  logic       reqA;
  logic       reqB;
  logic       Ago;
  logic       Ayel;
  logic       Astop;
  logic       Bgo;
  logic       Byel;
  logic       Bstop;
  logic [2:0] phase;
  logic       pendA;
  logic       pendB;

  modport slave (
    input  reqA, reqB,
    output Ago, Ayel, Astop, Bgo, Byel, Bstop, phase, pendA, pendB
  );

  modport master (
    output reqA, reqB,
    input  Ago, Ayel, Astop, Bgo, Byel, Bstop, phase, pendA, pendB
  );
endinterface

// File: rtl/signal_phase_scheduler.sv
// Demand-actuated phase scheduler for a two-road intersection.
// One green right-of-way is shared between roads A and B. Vehicle requests
// are latched into pending flags, and green is handed over only when the
// opposing road has pending demand, after min-green and (if the own road is
// still busy) max-green. Yellow and all-red clearance are fixed intervals.
// A single saturating phase counter restarts at zero in every state.
module signal_phase_scheduler #(
  parameter int unsigned NBITS       = 32,
  parameter logic [31:0] MIN_GREEN   = 32'h01C9C380,
  parameter logic [31:0] MAX_GREEN   = 32'h03938700,
  parameter logic [31:0] YELLOW_TIME = 32'h00989680,
  parameter logic [31:0] ALLRED_TIME = 32'h002FAF08
) (
  input  logic                     clk,
  input  logic                     reset,
  signal_phase_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    AGREEN  = 3'd1,
    AYELLOW = 3'd2,
    ACLR    = 3'd3,
    BGREEN  = 3'd4,
    BYELLOW = 3'd5,
    BCLR    = 3'd6
  } state_t;

  typedef struct packed {
    logic a_go;
    logic a_yel;
    logic a_stop;
    logic b_go;
    logic b_yel;
    logic b_stop;
  } lamps_t;

  localparam lamps_t ALL_RED = '{a_stop: 1'b1, b_stop: 1'b1, default: 1'b0};

  // Last counter value of each interval: the exit edge is taken on it.
  localparam logic [NBITS-1:0] MIN_LAST    = NBITS'(MIN_GREEN   - 32'd1);
  localparam logic [NBITS-1:0] MAX_LAST    = NBITS'(MAX_GREEN   - 32'd1);
  localparam logic [NBITS-1:0] YELLOW_LAST = NBITS'(YELLOW_TIME - 32'd1);
  localparam logic [NBITS-1:0] ALLRED_LAST = NBITS'(ALLRED_TIME - 32'd1);
  localparam logic [NBITS-1:0] CNT_SAT     = '1;

  state_t             state_q, state_d;
  logic [NBITS-1:0]   cnt_q, cnt_d;
  logic               pend_a_q, pend_a_d;
  logic               pend_b_q, pend_b_d;
  lamps_t             lamps_q, lamps_d;
  logic               state_change;

  // Next-state selection: fixed intervals plus demand-driven green hand-over.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      INIT:    if (cnt_q == ALLRED_LAST) state_d = AGREEN;
      AGREEN:  if (cnt_q >= MIN_LAST && pend_b_q && (!bus.reqA || cnt_q >= MAX_LAST))
                 state_d = AYELLOW;
      AYELLOW: if (cnt_q == YELLOW_LAST) state_d = ACLR;
      ACLR:    if (cnt_q == ALLRED_LAST) state_d = BGREEN;
      BGREEN:  if (cnt_q >= MIN_LAST && pend_a_q && (!bus.reqB || cnt_q >= MAX_LAST))
                 state_d = BYELLOW;
      BYELLOW: if (cnt_q == YELLOW_LAST) state_d = BCLR;
      BCLR:    if (cnt_q == ALLRED_LAST) state_d = AGREEN;
      default: state_d = INIT;  // unused code 7 recovers through INIT
    endcase
  end

  // Phase counter and demand latches; entering a green clears that road's
  // latch, and that clear beats a request seen on the same edge.
  always_comb begin
    state_change = (state_d != state_q);
    cnt_d        = state_change ? '0
                 : (cnt_q == CNT_SAT) ? cnt_q : cnt_q + NBITS'(1);
    if (state_d == AGREEN && state_q != AGREEN)
      pend_a_d = 1'b0;
    else
      pend_a_d = pend_a_q | (bus.reqA && state_q != AGREEN);
    if (state_d == BGREEN && state_q != BGREEN)
      pend_b_d = 1'b0;
    else
      pend_b_d = pend_b_q | (bus.reqB && state_q != BGREEN);
  end

  // Lamp decode of the upcoming state so the lamps register with the state.
  always_comb begin
    lamps_d = ALL_RED;
    case (state_d)
      AGREEN:  lamps_d = '{a_go: 1'b1, b_stop: 1'b1, default: 1'b0};
      AYELLOW: lamps_d = '{a_yel: 1'b1, b_stop: 1'b1, default: 1'b0};
      BGREEN:  lamps_d = '{b_go: 1'b1, a_stop: 1'b1, default: 1'b0};
      BYELLOW: lamps_d = '{b_yel: 1'b1, a_stop: 1'b1, default: 1'b0};
      default: lamps_d = ALL_RED;
    endcase
  end

  // State, counter, latch and lamp registers; reset forces all-red INIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values of the others regardless of statement order.
      state_q  <= INIT;
      cnt_q    <= '0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      lamps_q  <= ALL_RED;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      lamps_q  <= lamps_d;
    end
  end

  assign bus.phase = state_q;
  assign bus.pendA = pend_a_q;
  assign bus.pendB = pend_b_q;
  assign bus.Ago   = lamps_q.a_go;
  assign bus.Ayel  = lamps_q.a_yel;
  assign bus.Astop = lamps_q.a_stop;
  assign bus.Bgo   = lamps_q.b_go;
  assign bus.Byel  = lamps_q.b_yel;
  assign bus.Bstop = lamps_q.b_stop;

endmodule
